// File: rtl/regbank_pkg.sv
// Shared types and helpers for the parametrised register bank.
// Optional feature macro used by the bank: REGBANK_ZERO_REG_EN.
package regbank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when a register index addresses an existing register.
    function automatic logic in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regbank_read_port.sv
// One registered operand read port: range check, write forwarding, busy zeroing.
// With REGBANK_ZERO_REG_EN defined, index 0 always reads as zero.
module regbank_read_port
    import regbank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    input  logic [AW-1:0]                raddr,
    input  logic                         wr_acc,
    input  logic [AW-1:0]                waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         busy,
    output logic [WIDTH-1:0]             rdata
);

    logic [WIDTH-1:0] rd_next;

    always_comb begin
        rd_next = '0;
        if (busy) begin
            rd_next = '0;
        end else if (wr_acc && (waddr == raddr)) begin
            rd_next = wdata;
        end else if (in_range(32'(raddr), DEPTH)) begin
            rd_next = mem[raddr];
        end
`ifdef REGBANK_ZERO_REG_EN
        if (raddr == '0) begin
            rd_next = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= rd_next;
        end
    end

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: one write port, two registered read ports, debug port, clear sweep.
// Optional: define REGBANK_ZERO_REG_EN to hardwire register 0 to zero.
module reg_bank_param
    import regbank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done
);

    state_t                      state;
    logic [AW-1:0]               cnt;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wr_acc;
    logic                        dbg_ok;

    // Writes land only in IDLE; during CLEAR and DONE they are dropped.
    always_comb begin
        wr_acc = we && (state == IDLE) && in_range(32'(waddr), DEPTH);
        dbg_ok = in_range(32'(dbg_addr), DEPTH);
`ifdef REGBANK_ZERO_REG_EN
        if (waddr == '0) begin
            wr_acc = 1'b0;
        end
        if (dbg_addr == '0) begin
            dbg_ok = 1'b0;
        end
`endif
    end

    assign dbg_data = dbg_ok ? mem[dbg_addr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem      <= '0;
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            if (wr_acc) begin
                mem[waddr] <= wdata;
            end
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    regbank_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port_a (
        .clk    (clk),
        .rst    (rst),
        .mem    (mem),
        .raddr  (raddr_a),
        .wr_acc (wr_acc),
        .waddr  (waddr),
        .wdata  (wdata),
        .busy   (busy),
        .rdata  (rdata_a)
    );

    regbank_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port_b (
        .clk    (clk),
        .rst    (rst),
        .mem    (mem),
        .raddr  (raddr_b),
        .wr_acc (wr_acc),
        .waddr  (waddr),
        .wdata  (wdata),
        .busy   (busy),
        .rdata  (rdata_b)
    );

endmodule
